// File: rtl/decode_feed_ctrl.sv
// decode_feed_ctrl: in-order {pc, instr} queue between fetch and decode.
// A circular buffer with registered occupancy. Decode sees an entry one cycle
// after fetch pushes it. Flush empties the queue, and a saturating counter
// tracks cycles in which fetch was held off.
module decode_feed_ctrl #(
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned PC_WIDTH        = 12,
  parameter int unsigned INSTR_WIDTH     = 32,
  parameter int unsigned STALL_CNT_WIDTH = 16
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic                       fetch_valid,
  input  logic [PC_WIDTH-1:0]        fetch_pc,
  input  logic [INSTR_WIDTH-1:0]     fetch_instr,
  output logic                       fetch_ready,
  output logic                       dec_valid,
  input  logic                       dec_ready,
  output logic [PC_WIDTH-1:0]        dec_pc,
  output logic [INSTR_WIDTH-1:0]     dec_instr,
  output logic                       dec_illegal,
  output logic [$clog2(DEPTH):0]     count,
  output logic [STALL_CNT_WIDTH-1:0] stall_cycles
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] LP_FULL = CW'(DEPTH);

  // Opcodes the decoder supports (R-type, I-type ALU, LUI, loads, stores)
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_OP_IMM = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;

  logic [PC_WIDTH-1:0]        r_pc_mem    [DEPTH];
  logic [INSTR_WIDTH-1:0]     r_instr_mem [DEPTH];
  logic [AW-1:0]              r_wp;
  logic [AW-1:0]              r_rp;
  logic [CW-1:0]              r_count;
  logic [STALL_CNT_WIDTH-1:0] r_stall;

  logic w_fetch_ready;
  logic w_dec_valid;
  logic w_push;
  logic w_pop;
  logic w_stall_inc;
  logic w_op_known;

  // Handshake qualifiers; both ready and valid come from registered occupancy only
  always_comb begin
    w_fetch_ready = (r_count != LP_FULL);
    w_dec_valid   = (r_count != '0);
    w_push        = fetch_valid && w_fetch_ready;
    w_pop         = w_dec_valid && dec_ready;
    w_stall_inc   = fetch_valid && !w_fetch_ready && !flush;
  end

  // Queue storage, pointers and occupancy; flush overrides any handshake
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_pc_mem[i]    <= '0;
        r_instr_mem[i] <= '0;
      end
    end else if (flush) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_count <= '0;
    end else begin
      if (w_push) begin
        r_pc_mem[r_wp]    <= fetch_pc;
        r_instr_mem[r_wp] <= fetch_instr;
        r_wp              <= r_wp + 1'b1;
      end
      if (w_pop) begin
        r_rp <= r_rp + 1'b1;
      end
      if (w_push && !w_pop) begin
        r_count <= r_count + 1'b1;
      end else if (w_pop && !w_push) begin
        r_count <= r_count - 1'b1;
      end
    end
  end

  // Saturating back-pressure counter; survives flush
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_stall <= '0;
    end else if (w_stall_inc && (r_stall != '1)) begin
      r_stall <= r_stall + 1'b1;
    end
  end

  // Supported-opcode lookup on the head entry
  always_comb begin
    w_op_known = 1'b0;
    case (r_instr_mem[r_rp][6:0])
      OP_OP, OP_OP_IMM, OP_LUI, OP_LOAD, OP_STORE: w_op_known = 1'b1;
      default:                                     w_op_known = 1'b0;
    endcase
  end

  // Output drive
  always_comb begin
    fetch_ready  = w_fetch_ready;
    dec_valid    = w_dec_valid;
    dec_pc       = r_pc_mem[r_rp];
    dec_instr    = r_instr_mem[r_rp];
    dec_illegal  = w_dec_valid && !w_op_known;
    count        = r_count;
    stall_cycles = r_stall;
  end

endmodule

// File: tb/tb_decode_feed_ctrl.sv
// tb_decode_feed_ctrl: scenario tasks plus a scoreboard monitor for decode_feed_ctrl.
module tb_decode_feed_ctrl;

  localparam int DEPTH = 4;

  typedef struct {
    logic [11:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        fetch_valid;
  logic [11:0] fetch_pc;
  logic [31:0] fetch_instr;
  logic        fetch_ready;
  logic        dec_valid;
  logic        dec_ready;
  logic [11:0] dec_pc;
  logic [31:0] dec_instr;
  logic        dec_illegal;
  logic [2:0]  count;
  logic [15:0] stall_cycles;

  int checks   = 0;
  int failures = 0;

  entry_t      sb[$];
  logic [15:0] m_stall;
  int          max_count;

  decode_feed_ctrl #(
    .DEPTH(DEPTH),
    .PC_WIDTH(12),
    .INSTR_WIDTH(32),
    .STALL_CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .flush(flush),
    .fetch_valid(fetch_valid),
    .fetch_pc(fetch_pc),
    .fetch_instr(fetch_instr),
    .fetch_ready(fetch_ready),
    .dec_valid(dec_valid),
    .dec_ready(dec_ready),
    .dec_pc(dec_pc),
    .dec_instr(dec_instr),
    .dec_illegal(dec_illegal),
    .count(count),
    .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic exp_illegal(input logic [31:0] instr);
    logic [6:0] op;
    op = instr[6:0];
    return !(op == 7'h33 || op == 7'h13 || op == 7'h37 || op == 7'h03 || op == 7'h23);
  endfunction

  // Scoreboard: check head and occupancy, then apply the coming edge to the model
  always @(negedge clk) begin
    if (!rst_n) begin
      sb.delete();
      m_stall = '0;
    end else begin
      checks++;
      if (count !== 3'(sb.size()) || fetch_ready !== (sb.size() != DEPTH) ||
          dec_valid !== (sb.size() != 0)) begin
        failures++;
        $display("FAIL occupancy: count=%0d fetch_ready=%b dec_valid=%b expected count=%0d",
                 count, fetch_ready, dec_valid, sb.size());
      end
      checks++;
      if (stall_cycles !== m_stall) begin
        failures++;
        $display("FAIL stall_model: got %0d expected %0d", stall_cycles, m_stall);
      end
      if (sb.size() != 0) begin
        checks++;
        if (dec_pc !== sb[0].pc || dec_instr !== sb[0].instr ||
            dec_illegal !== exp_illegal(sb[0].instr)) begin
          failures++;
          $display("FAIL head_data: got pc=%h instr=%h ill=%b expected pc=%h instr=%h ill=%b",
                   dec_pc, dec_instr, dec_illegal, sb[0].pc, sb[0].instr,
                   exp_illegal(sb[0].instr));
        end
      end
      if (fetch_valid && sb.size() == DEPTH && !flush && m_stall != 16'hFFFF)
        m_stall = m_stall + 16'd1;
      if (flush) begin
        sb.delete();
      end else begin
        entry_t e;
        logic   do_push;
        do_push = fetch_valid && (sb.size() != DEPTH);
        e.pc    = fetch_pc;
        e.instr = fetch_instr;
        if (dec_ready && sb.size() != 0) void'(sb.pop_front());
        if (do_push) sb.push_back(e);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    fetch_pc    = '0;
    fetch_instr = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    #23;
    checks++;
    if (dec_valid !== 1'b0 || fetch_ready !== 1'b1 || count !== 3'd0 || stall_cycles !== 16'd0 ||
        dec_pc !== 12'h0 || dec_instr !== 32'h0 || dec_illegal !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: dv=%b fr=%b cnt=%0d st=%0d pc=%h in=%h ill=%b expected 0 1 0 0 0 0 0",
               dec_valid, fetch_ready, count, stall_cycles, dec_pc, dec_instr, dec_illegal);
    end
    tick();
    rst_n = 1'b1;
    tick();
    fetch_valid = 1'b1;
    fetch_pc    = 12'h004;
    fetch_instr = 32'h00500093;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (dec_valid !== 1'b1 || dec_pc !== 12'h004 || dec_illegal !== 1'b0) begin
      failures++;
      $display("FAIL first_push: dv=%b pc=%h ill=%b expected 1 004 0", dec_valid, dec_pc, dec_illegal);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
  endtask

  task automatic test_fill();
    dec_ready = 1'b0;
    fetch_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      fetch_pc    = 12'(4 * i);
      fetch_instr = 32'h00000013 | (32'(i) << 20);
      tick();
    end
    checks++;
    if (count !== 3'd4 || fetch_ready !== 1'b0) begin
      failures++;
      $display("FAIL fill_full: count=%0d fetch_ready=%b expected 4 0", count, fetch_ready);
    end
    fetch_pc    = 12'h010;
    fetch_instr = 32'h00000033;
    repeat (3) tick();
    checks++;
    if (stall_cycles !== 16'd3) begin
      failures++;
      $display("FAIL fill_stall: stall_cycles=%0d expected 3", stall_cycles);
    end
    fetch_valid = 1'b0;
  endtask

  task automatic test_full_handshake();
    logic [11:0] exp_pc[4];
    exp_pc[0] = 12'h004; exp_pc[1] = 12'h008; exp_pc[2] = 12'h00C; exp_pc[3] = 12'h100;
    fetch_valid = 1'b1;
    fetch_pc    = 12'h100;
    fetch_instr = 32'h12345037;
    dec_ready   = 1'b1;
    tick();
    checks++;
    if (count !== 3'd3 || stall_cycles !== 16'd4) begin
      failures++;
      $display("FAIL full_pop_only: count=%0d stall=%0d expected 3 4", count, stall_cycles);
    end
    dec_ready = 1'b0;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (count !== 3'd4) begin
      failures++;
      $display("FAIL full_next_push: count=%0d expected 4", count);
    end
    dec_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (dec_pc !== exp_pc[i] || dec_valid !== 1'b1) begin
        failures++;
        $display("FAIL drain_order[%0d]: pc=%h dv=%b expected %h 1", i, dec_pc, dec_valid, exp_pc[i]);
      end
      tick();
    end
    dec_ready = 1'b0;
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL drain_empty: count=%0d expected 0", count);
    end
  endtask

  task automatic test_back_to_back();
    max_count = 0;
    dec_ready = 1'b1;
    fetch_valid = 1'b1;
    for (int i = 0; i < 10; i++) begin
      fetch_pc    = 12'h200 + 12'(4 * i);
      fetch_instr = 32'h00002003 | (32'(i) << 15);
      tick();
      if (int'(count) > max_count) max_count = int'(count);
    end
    fetch_valid = 1'b0;
    repeat (3) tick();
    dec_ready = 1'b0;
    checks++;
    if (max_count > 2 || max_count < 1) begin
      failures++;
      $display("FAIL stream_occupancy: max count=%0d expected 1..2", max_count);
    end
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0) begin
      failures++;
      $display("FAIL stream_drained: count=%0d dv=%b expected 0 0", count, dec_valid);
    end
  endtask

  task automatic test_illegal();
    fetch_valid = 1'b1;
    fetch_pc    = 12'h300;
    fetch_instr = 32'h0000006F;
    tick();
    fetch_valid = 1'b0;
    checks++;
    if (dec_valid !== 1'b1 || dec_illegal !== 1'b1 || dec_instr !== 32'h0000006F) begin
      failures++;
      $display("FAIL illegal_flag: dv=%b ill=%b instr=%h expected 1 1 0000006f",
               dec_valid, dec_illegal, dec_instr);
    end
    dec_ready = 1'b1;
    tick();
    dec_ready = 1'b0;
    checks++;
    if (count !== 3'd0 || dec_illegal !== 1'b0) begin
      failures++;
      $display("FAIL illegal_pop: count=%0d ill=%b expected 0 0", count, dec_illegal);
    end
  endtask

  task automatic test_flush();
    fetch_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      fetch_pc    = 12'h400 + 12'(4 * i);
      fetch_instr = 32'h00000023;
      tick();
    end
    checks++;
    if (count !== 3'd3) begin
      failures++;
      $display("FAIL flush_setup: count=%0d expected 3", count);
    end
    flush       = 1'b1;
    dec_ready   = 1'b1;
    fetch_pc    = 12'h500;
    tick();
    flush       = 1'b0;
    fetch_valid = 1'b0;
    dec_ready   = 1'b0;
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1 || dec_illegal !== 1'b0) begin
      failures++;
      $display("FAIL flush_clear: count=%0d dv=%b fr=%b ill=%b expected 0 0 1 0",
               count, dec_valid, fetch_ready, dec_illegal);
    end
    tick();
    checks++;
    if (count !== 3'd0) begin
      failures++;
      $display("FAIL flush_no_push: count=%0d expected 0", count);
    end
  endtask

  task automatic test_reset_mid();
    fetch_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      fetch_pc    = 12'h600 + 12'(4 * i);
      fetch_instr = 32'h00000037;
      tick();
    end
    fetch_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (count !== 3'd0 || dec_valid !== 1'b0 || fetch_ready !== 1'b1 || stall_cycles !== 16'd0 ||
        dec_pc !== 12'h0 || dec_instr !== 32'h0) begin
      failures++;
      $display("FAIL async_reset: count=%0d dv=%b fr=%b st=%0d pc=%h in=%h expected 0 0 1 0 0 0",
               count, dec_valid, fetch_ready, stall_cycles, dec_pc, dec_instr);
    end
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_handshake();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
